// File: rtl/bytewrite_ram_pkg.sv
// bytewrite_ram_pkg: shared types and constants for the byte-write RAM arbiter.
// Holds the controller FSM encoding, default geometry and the ID width helper.
package bytewrite_ram_pkg;

  // Controller FSM: clear sweep after reset, then normal arbitration
  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_NUM_COL    = 4;
  localparam int DEF_COL_WIDTH  = 8;
  localparam int DEF_ADDR_WIDTH = 10;

  // Width of a requester index; never narrower than one bit
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bytewrite_ram_arbiter_if.sv
// bytewrite_ram_arbiter_if: request/response bus between client logic (master)
// and the RAM arbiter (slave). Requests are flattened per requester.
interface bytewrite_ram_arbiter_if
  import bytewrite_ram_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int NUM_COL    = DEF_NUM_COL,
  parameter int COL_WIDTH  = DEF_COL_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
  localparam int DATA_WIDTH = NUM_COL * COL_WIDTH;
  localparam int ID_WIDTH   = id_width(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*NUM_COL-1:0]    req_we;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic                          rsp_valid;
  logic [ID_WIDTH-1:0]           rsp_id;
  logic                          rsp_we;
  logic [DATA_WIDTH-1:0]         rsp_data;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_id, rsp_we, rsp_data
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_id, rsp_we, rsp_data
  );

endinterface

// File: rtl/bytewrite_ram_rr_arb.sv
// bytewrite_ram_rr_arb: single-cycle combinational arbiter.
// Build option BYTEWRITE_RAM_ARB_RR_EN: defined -> round-robin starting at
// i_ptr; undefined -> fixed priority (index 0 highest, no pointer input).
module bytewrite_ram_rr_arb
  import bytewrite_ram_pkg::*;
#(
  parameter int NUM_REQ  = DEF_NUM_REQ,
  parameter int ID_WIDTH = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  i_req,
`ifdef BYTEWRITE_RAM_ARB_RR_EN
  input  logic [ID_WIDTH-1:0] i_ptr,
`endif
  output logic [NUM_REQ-1:0]  o_grant,
  output logic [ID_WIDTH-1:0] o_id,
  output logic                o_any
);

  // Pick the first requesting index in search order and encode it
  always_comb begin
    int idx;
    idx     = 0;
    o_grant = '0;
    o_id    = '0;
    o_any   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
`ifdef BYTEWRITE_RAM_ARB_RR_EN
      idx = (int'(i_ptr) + k) % NUM_REQ;
`else
      idx = k;
`endif
      if (!o_any && i_req[idx]) begin
        o_any        = 1'b1;
        o_grant[idx] = 1'b1;
        o_id         = ID_WIDTH'(idx);
      end
    end
  end

endmodule

// File: rtl/bytewrite_ram_arbiter.sv
// bytewrite_ram_arbiter: shares one byte-write RAM port among NUM_REQ clients.
// Clears the RAM after reset, then grants one access per cycle through a
// registered command stage; responses return two cycles after the grant.
// Build option BYTEWRITE_RAM_ARB_RR_EN selects round-robin over fixed priority.
module bytewrite_ram_arbiter
  import bytewrite_ram_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int NUM_COL    = DEF_NUM_COL,
  parameter int COL_WIDTH  = DEF_COL_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst_n,
  bytewrite_ram_arbiter_if.slave           bus,
  output logic                             ram_en,
  output logic [NUM_COL-1:0]               ram_we,
  output logic [ADDR_WIDTH-1:0]            ram_addr,
  output logic [NUM_COL*COL_WIDTH-1:0]     ram_din,
  input  logic [NUM_COL*COL_WIDTH-1:0]     ram_dout,
  output logic                             init_done
);
  localparam int DATA_WIDTH = NUM_COL * COL_WIDTH;
  localparam int ID_WIDTH   = id_width(NUM_REQ);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  state_t                r_state, w_state_next;
  logic [ADDR_WIDTH-1:0] r_clr_addr;
  logic [NUM_REQ-1:0]    w_grant;
  logic [ID_WIDTH-1:0]   w_id;
  logic                  w_any, w_run, w_fire;

  logic                  r_ram_en;
  logic [NUM_COL-1:0]    r_ram_we;
  logic [ADDR_WIDTH-1:0] r_ram_addr;
  logic [DATA_WIDTH-1:0] r_ram_din;
  logic                  r_cmd_valid, r_cmd_we, r_rsp_valid, r_rsp_we;
  logic [ID_WIDTH-1:0]   r_cmd_id, r_rsp_id;

  logic [NUM_COL-1:0]    w_we_arr   [NUM_REQ];
  logic [ADDR_WIDTH-1:0] w_addr_arr [NUM_REQ];
  logic [DATA_WIDTH-1:0] w_wd_arr   [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign w_we_arr[gi]   = bus.req_we[gi*NUM_COL +: NUM_COL];
      assign w_addr_arr[gi] = bus.req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign w_wd_arr[gi]   = bus.req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

`ifdef BYTEWRITE_RAM_ARB_RR_EN
  logic [ID_WIDTH-1:0] r_rr_ptr;

  // Rotate priority past the last winner; hold when nothing was granted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_rr_ptr <= '0;
    else if (w_fire)
      r_rr_ptr <= (w_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : w_id + 1'b1;
  end
`endif

  bytewrite_ram_rr_arb #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_arb (
    .i_req   (bus.req_valid),
`ifdef BYTEWRITE_RAM_ARB_RR_EN
    .i_ptr   (r_rr_ptr),
`endif
    .o_grant (w_grant),
    .o_id    (w_id),
    .o_any   (w_any)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_INIT;
    else        r_state <= w_state_next;
  end

  // Leave INIT on the edge that issues the clear of the last address
  always_comb begin
    w_state_next = r_state;
    if (r_state == ST_INIT && r_clr_addr == LAST_ADDR)
      w_state_next = ST_RUN;
  end

  // Grants are only visible once the sweep is over
  always_comb begin
    w_run         = (r_state == ST_RUN);
    init_done     = w_run;
    bus.req_ready = w_run ? w_grant : '0;
    w_fire        = w_run & w_any;
  end

  // Clear counter walks the whole RAM and wraps back to zero on exit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 r_clr_addr <= '0;
    else if (r_state == ST_INIT) r_clr_addr <= r_clr_addr + 1'b1;
  end

  // RAM command register: clear writes during INIT, winner's access in RUN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ram_en   <= 1'b0;
      r_ram_we   <= '0;
      r_ram_addr <= '0;
      r_ram_din  <= '0;
    end else if (r_state == ST_INIT) begin
      r_ram_en   <= 1'b1;
      r_ram_we   <= '1;
      r_ram_addr <= r_clr_addr;
      r_ram_din  <= '0;
    end else begin
      r_ram_en <= w_fire;
      r_ram_we <= w_fire ? w_we_arr[w_id] : '0;
      if (w_fire) begin
        r_ram_addr <= w_addr_arr[w_id];
        r_ram_din  <= w_wd_arr[w_id];
      end
    end
  end

  // Response shadow: tracks the command stage, then lines up with ram_dout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd_valid <= 1'b0;
      r_cmd_id    <= '0;
      r_cmd_we    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_we    <= 1'b0;
    end else begin
      r_cmd_valid <= w_fire;
      r_cmd_id    <= w_id;
      r_cmd_we    <= w_fire & (|w_we_arr[w_id]);
      r_rsp_valid <= r_cmd_valid;
      r_rsp_id    <= r_cmd_id;
      r_rsp_we    <= r_cmd_we;
    end
  end

  assign ram_en        = r_ram_en;
  assign ram_we        = r_ram_we;
  assign ram_addr      = r_ram_addr;
  assign ram_din       = r_ram_din;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_we    = r_rsp_we;
  assign bus.rsp_data  = ram_dout;

endmodule
